// File: rtl/param_rf_pkg.sv
// param_rf_pkg: shared widths, word field layouts and read-source encoding for param_rf
package param_rf_pkg;

    localparam int ADDR_W        = 12;
    localparam int DEPTH_DEFAULT = 4096;
    localparam int PARAM_W       = 32;
    localparam int STATE_W       = 18;

    // Parameter word: i[31:24], z[23:16], k[15:8], l[7:0]
    localparam int P_FIELD_W = 8;
    localparam int P_I_LSB   = 24;
    localparam int P_Z_LSB   = 16;
    localparam int P_K_LSB   = 8;
    localparam int P_L_LSB   = 0;

    // State word: flags[17:13], level[12:5], position[4:0]
    localparam int S_POS_LSB  = 0;
    localparam int S_POS_W    = 5;
    localparam int S_LVL_LSB  = 5;
    localparam int S_LVL_W    = 8;
    localparam int S_FLAG_LSB = 13;
    localparam int S_FLAG_W   = 5;

    typedef struct packed {
        logic [P_FIELD_W-1:0] i;
        logic [P_FIELD_W-1:0] z;
        logic [P_FIELD_W-1:0] k;
        logic [P_FIELD_W-1:0] l;
    } param_word_t;

    typedef struct packed {
        logic [S_FLAG_W-1:0] flags;
        logic [S_LVL_W-1:0]  level;
        logic [S_POS_W-1:0]  position;
    } state_word_t;

    // Where the registered read data comes from
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_MEM,
        SEL_BYP
    } rd_sel_e;

    function automatic logic [S_POS_W-1:0] state_position(input logic [STATE_W-1:0] w);
        return w[S_POS_LSB +: S_POS_W];
    endfunction

endpackage

// File: rtl/param_rf_mem.sv
// param_rf_mem: storage array, two write ports, one registered read-first read port, contents not reset
module param_rf_mem
    import param_rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] wa_a_i,
    input  logic [DATA_W-1:0] wd_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] wa_b_i,
    input  logic [DATA_W-1:0] wd_b_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] ra_i,
    output logic [DATA_W-1:0] rd_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Writes and read share the edge, so the read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (we_a_i) mem_q[wa_a_i] <= wd_a_i;
        if (we_b_i) mem_q[wa_b_i] <= wd_b_i;
        if (re_i) rd_q <= mem_q[ra_i];
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/param_rf.sv
// param_rf: parameter/state register file with round-robin and random reads, append and random writes; PARAM_RF_BYPASS_EN enables write-first forwarding
module param_rf
    import param_rf_pkg::*;
#(
    parameter int DATA_W = param_rf_pkg::PARAM_W,
    parameter int ADDR_W = param_rf_pkg::ADDR_W,
    parameter int DEPTH  = param_rf_pkg::DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              re_seq_i,
    input  logic              re_ran_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              rvalid_o,
    input  logic              seq_we_i,
    input  logic [DATA_W-1:0] seq_w_data_i,
    input  logic              ran_we_i,
    input  logic [ADDR_W-1:0] ran_w_addr_i,
    input  logic [DATA_W-1:0] ran_w_data_i,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              err_o
);

`ifdef PARAM_RF_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]   used_q, used_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] byp_q, byp_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;
    logic              full_q, empty_q;
    rd_sel_e           sel_q, sel_d;

    logic              live, app_ok, wr_ok, ra_hit, app_fwd, wr_fwd, rd_req, rd_ok, seq_go, wrap, mem_re;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] mem_rd;

    // Request qualification, pointer/occupancy next state and read-source selection
    always_comb begin
        live     = rst_n && !clear_i;
        app_ok   = seq_we_i && !full_q;
        wr_ok    = ran_we_i && ({1'b0, ran_w_addr_i} < used_q);
        ra       = re_ran_i ? r_addr_i : rd_ptr_q;
        ra_hit   = {1'b0, r_addr_i} < used_q;
        app_fwd  = BYP_EN && re_ran_i && app_ok && ({1'b0, r_addr_i} == used_q);
        wr_fwd   = BYP_EN && wr_ok && (ran_w_addr_i == ra);
        rd_req   = re_ran_i || re_seq_i;
        rd_ok    = re_ran_i ? (ra_hit || app_fwd) : (re_seq_i && !empty_q);
        seq_go   = re_seq_i && !re_ran_i && !empty_q;
        wrap     = ({1'b0, rd_ptr_q} + (ADDR_W+1)'(1)) == used_q;
        mem_re   = live && rd_ok;
        used_d   = clear_i ? '0 : used_q + (ADDR_W+1)'(app_ok);
        rd_ptr_d = clear_i ? '0 : !seq_go ? rd_ptr_q : wrap ? '0 : rd_ptr_q + ADDR_W'(1);
        err_d    = !clear_i && (err_q || (seq_we_i && full_q) || (ran_we_i && !wr_ok) || (re_ran_i && !rd_ok));
        addr_d   = (clear_i || !rd_req) ? addr_q : re_ran_i ? r_addr_i : empty_q ? '0 : rd_ptr_q;
        rvalid_d = !clear_i && rd_ok;
        sel_d    = (clear_i || !rd_req) ? sel_q : !rd_ok ? SEL_ZERO : (app_fwd || wr_fwd) ? SEL_BYP : SEL_MEM;
        byp_d    = !mem_re ? byp_q : app_fwd ? seq_w_data_i : ran_w_data_i;
    end

    // Control registers; reset discards the cycle's requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            used_q   <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            sel_q    <= SEL_ZERO;
            byp_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            used_q   <= used_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            sel_q    <= sel_d;
            byp_q    <= byp_d;
            full_q   <= used_d == DEPTH_C;
            empty_q  <= used_d == '0;
        end
    end

    param_rf_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we_a_i(live && app_ok),
        .wa_a_i(used_q[ADDR_W-1:0]),
        .wd_a_i(seq_w_data_i),
        .we_b_i(live && wr_ok),
        .wa_b_i(ran_w_addr_i),
        .wd_b_i(ran_w_data_i),
        .re_i  (mem_re),
        .ra_i  (ra),
        .rd_o  (mem_rd)
    );

    assign data_o   = (sel_q == SEL_MEM) ? mem_rd : (sel_q == SEL_BYP) ? byp_q : '0;
    assign addr_o   = addr_q;
    assign rvalid_o = rvalid_q;
    assign count_o  = used_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_param_rf.sv
// tb_param_rf: randomized scoreboard bench for param_rf (DEPTH=4, DATA_W=32); honours PARAM_RF_BYPASS_EN
module tb_param_rf;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DP = 4;

`ifdef PARAM_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic          rst_n, clr, rs, rr;
        logic [AW-1:0] ra;
        logic          sw;
        logic [DW-1:0] sd;
        logic          rw;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } req_t;

    typedef struct packed {
        logic          rv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW:0]   cnt;
        logic          err, full, empty;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, clear_i = 1'b0, re_seq_i = 1'b0, re_ran_i = 1'b0;
    logic [AW-1:0] r_addr_i = '0, ran_w_addr_i = '0, addr_o;
    logic [DW-1:0] seq_w_data_i = '0, ran_w_data_i = '0, data_o;
    logic          seq_we_i = 1'b0, ran_we_i = 1'b0, rvalid_o, empty_o, full_o, err_o;
    logic [AW:0]   count_o;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    logic [DW-1:0] m_mem [DP];
    int            m_used = 0, m_ptr = 0;
    logic          m_err = 0, m_rv = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    param_rf #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .re_seq_i(re_seq_i), .re_ran_i(re_ran_i),
        .r_addr_i(r_addr_i), .addr_o(addr_o), .data_o(data_o), .rvalid_o(rvalid_o),
        .seq_we_i(seq_we_i), .seq_w_data_i(seq_w_data_i), .ran_we_i(ran_we_i),
        .ran_w_addr_i(ran_w_addr_i), .ran_w_data_i(ran_w_data_i), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one clock edge, straight from the table's rules
    task automatic model(input req_t r);
        if (!r.rst_n) begin
            m_used = 0; m_ptr = 0; m_err = 0; m_rv = 0; m_addr = '0; m_data = '0;
        end else if (r.clr) begin
            m_used = 0; m_ptr = 0; m_err = 0; m_rv = 0;
        end else begin
            m_rv = 0;
            if (r.rr) begin
                m_addr = r.ra;
                if (int'(r.ra) < m_used) begin
                    m_data = (BYP && r.rw && r.wa == r.ra) ? r.wd : m_mem[r.ra];
                    m_rv = 1;
                end else if (BYP && r.sw && m_used < DP && int'(r.ra) == m_used) begin
                    m_data = r.sd;
                    m_rv = 1;
                end else begin
                    m_data = '0;
                    m_err = 1;
                end
            end else if (r.rs) begin
                if (m_used > 0) begin
                    m_addr = AW'(m_ptr);
                    m_data = (BYP && r.rw && int'(r.wa) == m_ptr) ? r.wd : m_mem[m_ptr];
                    m_rv = 1;
                    m_ptr = (m_ptr + 1 == m_used) ? 0 : m_ptr + 1;
                end else begin
                    m_addr = '0;
                    m_data = '0;
                end
            end
            if (r.rw) begin
                if (int'(r.wa) < m_used) m_mem[r.wa] = r.wd;
                else m_err = 1;
            end
            if (r.sw) begin
                if (m_used < DP) begin
                    m_mem[m_used] = r.sd;
                    m_used++;
                end else m_err = 1;
            end
        end
    endtask

    task automatic step(input req_t r);
        exp_t e;
        @(negedge clk);
        rst_n = r.rst_n; clear_i = r.clr; re_seq_i = r.rs; re_ran_i = r.rr; r_addr_i = r.ra;
        seq_we_i = r.sw; seq_w_data_i = r.sd; ran_we_i = r.rw; ran_w_addr_i = r.wa; ran_w_data_i = r.wd;
        model(r);
        e.rv = m_rv; e.a = m_addr; e.d = m_data; e.cnt = (AW+1)'(m_used);
        e.err = m_err; e.full = (m_used == DP); e.empty = (m_used == 0);
        q.push_back(e);
    endtask

    function automatic req_t nop();
        req_t r = '0;
        r.rst_n = 1'b1;
        return r;
    endfunction

    task automatic idle();
        step(nop());
    endtask

    task automatic app(input logic [DW-1:0] d);
        req_t r = nop();
        r.sw = 1'b1; r.sd = d;
        step(r);
    endtask

    task automatic sread();
        req_t r = nop();
        r.rs = 1'b1;
        step(r);
    endtask

    task automatic rread(input logic [AW-1:0] a);
        req_t r = nop();
        r.rr = 1'b1; r.ra = a;
        step(r);
    endtask

    task automatic clr();
        req_t r = nop();
        r.clr = 1'b1;
        step(r);
    endtask

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: one expected response per driven cycle, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rvalid", DW'(rvalid_o), DW'(e.rv));
                chk("addr", DW'(addr_o), DW'(e.a));
                chk("data", data_o, e.d);
                chk("count", DW'(count_o), DW'(e.cnt));
                chk("err", DW'(err_o), DW'(e.err));
                chk("full", DW'(full_o), DW'(e.full));
                chk("empty", DW'(empty_o), DW'(e.empty));
            end
        end
    end

    initial begin
        req_t r;
        r = '0;
        step(r);
        step(r);
        sread();
        idle();
        app(32'hA0); app(32'hA1); app(32'hA2);
        repeat (4) sread();
        idle();
        clr();
        for (int i = 0; i < 5; i++) app(32'hB0 + i);
        rread(12'd3);
        rread(12'd4);
        clr();
        app(32'h11); app(32'h22);
        r = nop(); r.rw = 1'b1; r.wa = 12'd1; r.wd = 32'hCC; r.sw = 1'b1; r.sd = 32'hDD;
        step(r);
        rread(12'd1); rread(12'd2);
        r = nop(); r.rr = 1'b1; r.ra = 12'd1; r.rw = 1'b1; r.wa = 12'd1; r.wd = 32'hEE;
        step(r);
        rread(12'd1);
        r = nop(); r.rr = 1'b1; r.ra = 12'd3; r.sw = 1'b1; r.sd = 32'h77;
        step(r);
        r = nop(); r.rs = 1'b1; r.rr = 1'b1; r.ra = 12'd0;
        step(r);
        sread();
        clr();
        app(32'h1); app(32'h2); app(32'h3);
        r = nop(); r.clr = 1'b1; r.sw = 1'b1; r.sd = 32'h99;
        step(r);
        sread();
        r = nop(); r.rst_n = 1'b0; r.sw = 1'b1; r.sd = 32'h55;
        step(r);
        idle();
        for (int i = 0; i < 800; i++) begin
            r.rst_n = ($urandom_range(99) != 0);
            r.clr   = ($urandom_range(24) == 0);
            r.rs    = $urandom_range(1);
            r.rr    = ($urandom_range(2) == 0);
            r.ra    = AW'($urandom_range(5));
            r.sw    = ($urandom_range(2) == 0);
            r.sd    = $urandom;
            r.rw    = ($urandom_range(2) == 0);
            r.wa    = AW'($urandom_range(5));
            r.wd    = $urandom;
            step(r);
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_rf.md
# param_rf

Dual-access parameter register file that serves the accelerator's recursion-parameter and per-parameter state storage: the responder end of the sequential/random read and sequential/random write ports driven by the accelerator control FSM. One instance holds the 32-bit parameter words, and a second instance holds the 18-bit state words. Sequential reads scan the occupied entries round-robin. Sequential writes append new recursion calls at the tail. Random reads and writes access an addressed entry.

## Interface
- DATA_W, 32: entry width; 32 for parameter words, 18 for state words.
- ADDR_W, 12: address width.
- DEPTH, 4096: number of entries; must be ≤ 2**ADDR_W.

- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- clear_i  in  1  synchronous flush: empties the table and clears the error flag.
- re_seq_i  in  1  sequential read enable.
- re_ran_i  in  1  random read enable.
- r_addr_i  in  ADDR_W  random read address.
- addr_o  out  ADDR_W  address of the entry that was returned.
- data_o  out  DATA_W  data of the entry that was returned.
- rvalid_o  out  1  addr_o/data_o hold a valid entry.
- seq_we_i  in  1  append enable.
- seq_w_data_i  in  DATA_W  append data.
- ran_we_i  in  1  random write enable.
- ran_w_addr_i  in  ADDR_W  random write address.
- ran_w_data_i  in  DATA_W  random write data.
- count_o  out  ADDR_W+1  number of occupied entries (used).
- empty_o / full_o  out  1  used==0 / used==DEPTH.
- err_o  out  1  sticky: set by a dropped append or an out-of-range access.

## Operation
- State: mem[DEPTH], rd_ptr, used, err. Occupied entries are indices 0..used-1. Entries are never removed individually.
- Random read (re_ran_i):
  - if r_addr_i < used: addr_o=r_addr_i, data_o=mem[r_addr_i], rvalid_o=1.
  - otherwise: addr_o=r_addr_i, data_o=0, rvalid_o=0, err set.
- Sequential read (re_seq_i, re_ran_i low):
  - if used>0: addr_o=rd_ptr, data_o=mem[rd_ptr], rvalid_o=1. rd_ptr advances to rd_ptr+1, or wraps to 0 when rd_ptr+1==used.
  - if empty: addr_o=0, data_o=0, rvalid_o=0, pointer unchanged, no error.
- Both read enables high: the random read wins and rd_ptr does not move.
- No read enable: addr_o and data_o hold their values; rvalid_o=0.
- Append (seq_we_i):
  - if !full: mem[used] written, used+1.
  - if full: write dropped, err set.
- Random write (ran_we_i):
  - if ran_w_addr_i < used: mem[ran_w_addr_i] written.
  - otherwise: ignored, err set.
- Append and random write in the same cycle: both performed. The targets are always distinct, because the random range check uses the pre-append value of used.
- Read-during-write to the same address: the read returns the old data (read-first). A same-cycle append is not visible to reads until the next cycle.
- clear_i: used=0, rd_ptr=0, err=0, rvalid_o=0. clear_i overrides every other request in that cycle; memory contents are untouched.
- Arithmetic: used is ADDR_W+1 bits wide and never exceeds DEPTH. rd_ptr is compared against used-1 and never wraps through the DEPTH boundary.

## Timing
- Read latency is 1 cycle: the enable is sampled at edge N, and addr_o/data_o/rvalid_o are valid after edge N, stable for the whole cycle N+1.
- Writes take effect at the sampling edge. count_o, full_o and empty_o are registered and reflect the new used after that edge.
- Reset (rst_n low at an edge): rd_ptr=0, used=0, err_o=0, addr_o=0, data_o=0, rvalid_o=0, count_o=0, empty_o=1, full_o=0.
  - Reset mid-scan or mid-write is honoured immediately: any write request in the reset cycle is discarded.
- Every request is a single-cycle strobe. There is no backpressure: the block accepts a request every cycle.

## Configuration
- PARAM_RF_BYPASS_EN defined: a read of an address being random-written in the same cycle returns the new write data (write-first forwarding). A same-cycle append to index used, read with r_addr_i==used, also returns the new data with rvalid_o=1 and is not flagged as an error.
- PARAM_RF_BYPASS_EN undefined: read-first as described under Operation.

## Structure
- Shared package holds:
  - ADDR_W, DEPTH_DEFAULT, and the widths 32 and 18.
  - Parameter-word field offsets: i[31:24], z[23:16], k[15:8], l[7:0].
  - State-word field offsets, including position[4:0].
- Sub-module param_rf_mem: the storage array with two write ports and one read port, read-first, with no reset on contents. param_rf itself contains the pointers, range checks, priority logic, bypass and flags.

## Test plan
All scenarios use DEPTH=4, DATA_W=32.
- Reset, then re_seq_i for 1 cycle -> rvalid_o=0, addr_o=0, data_o=0, empty_o=1, err_o=0.
- Append 0xA0, 0xA1, 0xA2, then 4 sequential reads -> addr_o=0,1,2,0 with data 0xA0,0xA1,0xA2,0xA0; count_o=3.
- Append 5 words 0xB0..0xB4 -> full_o=1 after the 4th; the 5th is dropped; err_o=1; random read of addr 3 returns 0xB3.
- With used=2, assert ran_we_i addr 1 data 0xCC together with seq_we_i data 0xDD -> next cycle mem[1]=0xCC, mem[2]=0xDD, count_o=3, err_o=0.
- Random read of addr 1 in the same cycle as a random write of 0xEE to addr 1 -> data_o returns the old value; with PARAM_RF_BYPASS_EN it returns 0xEE.
- With used=3, assert clear_i together with seq_we_i -> count_o=0, err_o=0, the append is discarded, and a subsequent sequential read gives rvalid_o=0.
